// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// fb_pkg : shared frame-buffer sizing defaults and loader state encoding
// Rev 1.0
// ============================================================================
package fb_pkg;

  localparam int FB_DATA_WIDTH = 8;
  localparam int FB_RAM_DEPTH  = 640 * 480;

  typedef logic [1:0] ld_state_t;

  localparam ld_state_t LD_IDLE = 2'd0;
  localparam ld_state_t LD_LOAD = 2'd1;
  localparam ld_state_t LD_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// fb_port_arbiter_if : ROM read port and single-port frame RAM bus
// Rev 1.0
// ============================================================================
interface fb_port_arbiter_if #(
  parameter int DATA_WIDTH = fb_pkg::FB_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(fb_pkg::FB_RAM_DEPTH)
) ();

  logic                  rom_en_o;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_data_i;
  logic                  ram_en_o;
  logic                  ram_we_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [DATA_WIDTH-1:0] ram_data_o;

  // Arbiter side
  modport master (
    output rom_en_o,
    output rom_addr_o,
    input  rom_data_i,
    output ram_en_o,
    output ram_we_o,
    output ram_addr_o,
    output ram_data_o
  );

  // ROM/RAM side
  modport slave (
    input  rom_en_o,
    input  rom_addr_o,
    output rom_data_i,
    input  ram_en_o,
    input  ram_we_o,
    input  ram_addr_o,
    input  ram_data_o
  );

endinterface
`default_nettype wire

// File: rtl/fb_scan_counter.sv
`default_nettype none
// ============================================================================
// fb_scan_counter : VGA scan-out read address with wrap and frame-origin clear
// Rev 1.0
// ============================================================================
module fb_scan_counter
  import fb_pkg::*;
#(
  parameter int RAM_DEPTH  = FB_RAM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_grant,
  input  wire logic                  i_frame_start,
  output logic      [ADDR_WIDTH-1:0] o_scan_addr,
  output logic                       o_frame_wrap
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(RAM_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] scan_addr_q;
  logic [ADDR_WIDTH-1:0] scan_addr_d;

  // A grant coinciding with frame origin still reads the old address,
  // so the counter lands one past zero.
  always_comb begin
    scan_addr_d = scan_addr_q;
    if (i_frame_start) begin
      scan_addr_d = i_grant ? ADDR_WIDTH'(1) : '0;
    end else if (i_grant) begin
      scan_addr_d = (scan_addr_q == c_last_addr) ? '0 : scan_addr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_addr_q <= '0;
    end else begin
      scan_addr_q <= scan_addr_d;
    end
  end

  assign o_scan_addr  = scan_addr_q;
  assign o_frame_wrap = i_grant && (scan_addr_q == c_last_addr);

endmodule
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
// fb_port_arbiter : frame RAM owner; VGA reads take priority over ROM->RAM load
// Rev 1.0
// ============================================================================
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int RAM_DEPTH  = FB_RAM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  wire logic         clk_i_fba,
  input  wire logic         rstn_i_fba,
  input  wire logic         start_i,
  fb_port_arbiter_if.master mem,
  input  wire logic         p_tick_i,
  input  wire logic         video_on_i,
  input  wire logic         frame_start_i,
  output logic              pix_valid_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              frame_wrap_o
);

  localparam int                     c_cnt_width = $clog2(RAM_DEPTH + 1);
  localparam logic [c_cnt_width-1:0] c_depth     = c_cnt_width'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  c_last_addr = ADDR_WIDTH'(RAM_DEPTH - 1);

  ld_state_t               state_q, state_d;
  logic [c_cnt_width-1:0]  rd_addr_q, rd_addr_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    pend_fresh_q, pend_fresh_d;
  logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic                    pix_valid_q, pix_valid_d;

  logic                    w_grant;
  logic                    w_retire;
  logic                    w_issue;
  logic                    w_last_write;
  logic                    w_start;
  logic [DATA_WIDTH-1:0]   w_pend_data;
  logic [ADDR_WIDTH-1:0]   w_scan_addr;
  logic                    w_frame_wrap;

  // Reset gates every request so nothing reaches the RAM in the reset cycle.
  assign w_grant      = p_tick_i & video_on_i & ~rstn_i_fba;
  assign w_retire     = pend_valid_q & ~w_grant & ~rstn_i_fba;
  assign w_issue      = (state_q == LD_LOAD) & ~rstn_i_fba & (rd_addr_q < c_depth)
                      & (~pend_valid_q | w_retire);
  assign w_last_write = w_retire & (pend_addr_q == c_last_addr);
  assign w_start      = start_i & (state_q != LD_LOAD);
  // ROM data arrives the cycle after issue; afterwards it lives in pend_data_q.
  assign w_pend_data  = pend_fresh_q ? mem.rom_data_i : pend_data_q;

  fb_scan_counter #(
    .RAM_DEPTH  (RAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scan (
    .clk           (clk_i_fba),
    .rst           (rstn_i_fba),
    .i_grant       (w_grant),
    .i_frame_start (frame_start_i),
    .o_scan_addr   (w_scan_addr),
    .o_frame_wrap  (w_frame_wrap)
  );

  always_ff @(posedge clk_i_fba) begin
    if (rstn_i_fba) begin
      state_q <= LD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE: if (start_i)      state_d = LD_LOAD;
      LD_LOAD: if (w_last_write) state_d = LD_DONE;
      LD_DONE: if (start_i)      state_d = LD_LOAD;
      default:                   state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    rd_addr_d = rd_addr_q;
    if (w_start) begin
      rd_addr_d = '0;
    end else if (w_issue) begin
      rd_addr_d = rd_addr_q + c_cnt_width'(1);
    end
    pend_valid_d = w_issue | (pend_valid_q & ~w_retire);
    pend_fresh_d = w_issue;
    pend_addr_d  = w_issue ? rd_addr_q[ADDR_WIDTH-1:0] : pend_addr_q;
    pend_data_d  = w_pend_data;
    pix_valid_d  = w_grant;
  end

  always_ff @(posedge clk_i_fba) begin
    if (rstn_i_fba) begin
      rd_addr_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_fresh_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pix_valid_q  <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_fresh_q <= pend_fresh_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pix_valid_q  <= pix_valid_d;
    end
  end

  always_comb begin
    mem.rom_en_o   = w_issue;
    mem.rom_addr_o = w_issue ? rd_addr_q[ADDR_WIDTH-1:0] : '0;
    mem.ram_en_o   = 1'b0;
    mem.ram_we_o   = 1'b0;
    mem.ram_addr_o = '0;
    mem.ram_data_o = '0;
    if (w_grant) begin
      mem.ram_en_o   = 1'b1;
      mem.ram_addr_o = w_scan_addr;
    end else if (w_retire) begin
      mem.ram_en_o   = 1'b1;
      mem.ram_we_o   = 1'b1;
      mem.ram_addr_o = pend_addr_q;
      mem.ram_data_o = w_pend_data;
    end
    pix_valid_o  = pix_valid_q & ~rstn_i_fba;
    load_busy_o  = (state_q == LD_LOAD) & ~rstn_i_fba;
    load_done_o  = (state_q == LD_DONE) & ~rstn_i_fba;
    frame_wrap_o = w_frame_wrap;
  end

endmodule
`default_nettype wire
